// File: rtl/div_iter_pkg.sv
// Shared CPU definitions: ALU operation codes and the iterative divider state encoding.
package div_iter_pkg;

    localparam logic [7:0] ALU_OP_NOP   = 8'b0000_0000;
    localparam logic [7:0] ALU_OP_ADD   = 8'b0010_0000;
    localparam logic [7:0] ALU_OP_SUB   = 8'b0010_0010;
    localparam logic [7:0] ALU_OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] ALU_OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] ALU_OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] ALU_OP_DIVU  = 8'b0001_1011;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negate; yields a magnitude when i_negate is the sign bit.
module div_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per clock.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 annul,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 busy,
    output logic                 div_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_negQuo;
    logic               r_negRem;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;
    logic               r_busy;
    logic               r_divZero;

    logic               w_negA;
    logic               w_negB;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_nextRem;
    logic [WIDTH-1:0]   w_nextQuo;
    logic [WIDTH-1:0]   w_finalRem;
    logic [WIDTH-1:0]   w_finalQuo;

    assign w_negA = signed_div & opdata1[WIDTH-1];
    assign w_negB = signed_div & opdata2[WIDTH-1];

    div_abs #(.WIDTH(WIDTH)) u_absA (.i_value(opdata1), .i_negate(w_negA), .o_value(w_absA));
    div_abs #(.WIDTH(WIDTH)) u_absB (.i_value(opdata2), .i_negate(w_negB), .o_value(w_absB));

    // Partial remainder is always below the divisor, so one extra bit holds the shifted trial.
    assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_divisor};
    assign w_fits    = ~w_trial[WIDTH];
    assign w_nextRem = w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_nextQuo = {r_quo[WIDTH-2:0], w_fits};

    div_abs #(.WIDTH(WIDTH)) u_fixQuo (.i_value(w_nextQuo), .i_negate(r_negQuo), .o_value(w_finalQuo));
    div_abs #(.WIDTH(WIDTH)) u_fixRem (.i_value(w_nextRem), .i_negate(r_negRem), .o_value(w_finalRem));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_negQuo  <= 1'b0;
            r_negRem  <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    if (start && !annul) begin
                        r_quo     <= w_absA;
                        r_divisor <= w_absB;
                        r_rem     <= '0;
                        r_negQuo  <= w_negA ^ w_negB;
                        r_negRem  <= w_negA;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_divZero <= 1'b0;
                        r_state   <= (opdata2 == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    r_busy <= 1'b0;
                    if (annul) begin
                        r_state <= IDLE;
                    end else begin
                        r_result  <= '0;
                        r_divZero <= 1'b1;
                        r_ready   <= 1'b1;
                        r_state   <= END;
                    end
                end
                ON: begin
                    if (annul) begin
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_rem <= w_nextRem;
                        r_quo <= w_nextQuo;
                        r_cnt <= r_cnt + CW'(1);
                        // The last step writes the sign-corrected result directly.
                        if (r_cnt == LAST_STEP) begin
                            r_result  <= {w_finalRem, w_finalQuo};
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_cnt     <= '0;
                            r_state   <= END;
                        end
                    end
                end
                END: begin
                    if (annul || !start) begin
                        r_ready <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign result   = r_result;
    assign ready    = r_ready;
    assign busy     = r_busy;
    assign div_zero = r_divZero;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus randomized divides against a reference model.
module tb_div_iter;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic           annul;
    logic           signed_div;
    logic [W-1:0]   opdata1;
    logic [W-1:0]   opdata2;
    logic [2*W-1:0] result;
    logic           ready;
    logic           busy;
    logic           div_zero;

    int totalCount = 0;
    int badCount   = 0;

    div_iter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .annul      (annul),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready),
        .busy       (busy),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: {div_zero, remainder, quotient} from plain integer arithmetic.
    function automatic logic [2*W:0] refDivide(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == 0) return {1'b1, {(2*W){1'b0}}};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[W-1:0];
            r  = sr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, r, q};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 input logic st, input logic an);
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = st;
        annul      = an;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Full handshake: accept, scramble operands, time the latency, hold in END, release.
    task automatic runDivide(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                             input int holdCycles, input string tag);
        logic [2*W:0] exp;
        int lat;
        int expLat;
        exp    = refDivide(a, b, s);
        expLat = (b == 0) ? 1 : W;
        applyStimulus(a, b, s, 1'b1, 1'b0);
        stepClock();
        checkOutput({tag, ".busy"}, busy, 1);
        applyStimulus($urandom, $urandom, ~s, 1'b1, 1'b0);
        lat = 0;
        while (!ready && lat < 200) begin
            stepClock();
            lat++;
        end
        checkOutput({tag, ".latency"}, lat, expLat);
        checkOutput({tag, ".result"}, result, exp[2*W-1:0]);
        checkOutput({tag, ".div_zero"}, div_zero, exp[2*W]);
        checkOutput({tag, ".busy_end"}, busy, 0);
        for (int i = 1; i < holdCycles; i++) begin
            stepClock();
            checkOutput({tag, ".hold_ready"}, ready, 1);
            checkOutput({tag, ".hold_result"}, result, exp[2*W-1:0]);
        end
        start = 1'b0;
        stepClock();
        checkOutput({tag, ".release"}, ready, 0);
    endtask

    initial begin
        int readySeen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
        stepClock();
        stepClock();
        checkOutput("reset.result", result, 0);
        checkOutput("reset.ready", ready, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.div_zero", div_zero, 0);
        rst = 1'b0;
        start = 1'b0;
        stepClock();

        runDivide(32'd100, 32'd7, 1'b0, 1, "u100div7");
        runDivide(32'hFFFFFF9C, 32'd7, 1'b1, 1, "sneg100div7");
        runDivide(32'd5, 32'd0, 1'b0, 1, "divzero");
        runDivide(32'h80000000, 32'hFFFFFFFF, 1'b1, 1, "minneg");
        runDivide(32'hFFFFFFFF, 32'd1, 1'b0, 1, "umaxdiv1");
        runDivide(32'd12345, 32'd17, 1'b0, 5, "hold5");

        // Abandon a divide at step 10; no ready may follow.
        applyStimulus(32'd1000, 32'd3, 1'b0, 1'b1, 1'b0);
        stepClock();
        start = 1'b0;
        for (int i = 0; i < 9; i++) stepClock();
        annul = 1'b1;
        stepClock();
        checkOutput("annulOn.busy", busy, 0);
        checkOutput("annulOn.ready", ready, 0);
        annul = 1'b0;
        readySeen = 0;
        for (int i = 0; i < 40; i++) begin
            stepClock();
            if (ready) readySeen++;
        end
        checkOutput("annulOn.noReady", readySeen, 0);
        runDivide(32'd9, 32'd3, 1'b0, 1, "afterAnnul");

        // Annul in BYZERO.
        applyStimulus(32'd5, 32'd0, 1'b0, 1'b1, 1'b1);
        annul = 1'b0;
        stepClock();
        start = 1'b0;
        annul = 1'b1;
        stepClock();
        checkOutput("annulZero.busy", busy, 0);
        checkOutput("annulZero.ready", ready, 0);
        annul = 1'b0;
        stepClock();
        checkOutput("annulZero.idle", ready, 0);

        // Annul in END while start is still held.
        applyStimulus(32'd50, 32'd5, 1'b0, 1'b1, 1'b0);
        stepClock();
        readySeen = 0;
        while (!ready && readySeen < 200) begin
            stepClock();
            readySeen++;
        end
        checkOutput("annulEnd.reached", ready, 1);
        annul = 1'b1;
        stepClock();
        checkOutput("annulEnd.ready", ready, 0);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        stepClock();

        // Reset mid-divide.
        applyStimulus(32'hDEADBEEF, 32'd13, 1'b0, 1'b1, 1'b0);
        stepClock();
        start = 1'b0;
        for (int i = 0; i < 5; i++) stepClock();
        rst = 1'b1;
        stepClock();
        checkOutput("midReset.result", result, 0);
        checkOutput("midReset.ready", ready, 0);
        checkOutput("midReset.busy", busy, 0);
        checkOutput("midReset.div_zero", div_zero, 0);
        rst = 1'b0;
        stepClock();
        checkOutput("midReset.idle", busy, 0);

        // Randomized divides, with small and zero divisors mixed in.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 4 == 1) rb = W'($urandom_range(0, 15));
            if (n % 7 == 3) rb = '0;
            if (n % 5 == 2) rb = {W{1'b1}};
            runDivide(ra, rb, 1'($urandom_range(0, 1)), 1, $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
